line_burst_adaptor: RTL and testbench

Converts single 256-bit cache line transfers into 4-beat 64-bit bursts on the physical memory bus. It sits directly downstream of the cache datapath/controller: it consumes that block's `pmem_address`, `pmem_wdata` and read/write strobes, and returns the assembled `pmem_rdata` line with a one-cycle response. Fills and writebacks are each a single registered burst transaction.

---
 rtl/line_burst_adaptor.sv | 81 ++++++++
 tb/tb_line_burst_adaptor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: splits 256-bit cache line fills/writebacks into 4-beat 64-bit memory bursts
module line_burst_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR, WR_DONE} state_t;
  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        cnt_n;
  logic [s_line-1:0] wbuf;
  assign cnt_n = cnt + 2'd1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      wbuf      <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (write_i) begin
            wbuf      <= line_i;
            burst_o   <= line_i[s_burst-1:0];
            address_o <= {address_i[31:5], 5'b0};
            write_o   <= 1'b1;
            state     <= WR;
          end else if (read_i) begin
            address_o <= {address_i[31:5], 5'b0};
            read_o    <= 1'b1;
            state     <= RD;
          end
        end
        RD: if (resp_i) begin
          line_o[s_burst*cnt +: s_burst] <= burst_i;
          cnt <= cnt_n;
          if (cnt == 2'd3) begin
            read_o <= 1'b0;
            resp_o <= 1'b1;
            state  <= RD_DONE;
          end
        end
        // next beat is preloaded so burst_o is valid as soon as the previous beat is taken
        WR: if (resp_i) begin
          burst_o <= wbuf[s_burst*cnt_n +: s_burst];
          cnt     <= cnt_n;
          if (cnt == 2'd3) begin
            write_o <= 1'b0;
            resp_o  <= 1'b1;
            state   <= WR_DONE;
          end
        end
        RD_DONE, WR_DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_burst_adaptor.sv
// tb_line_burst_adaptor: directed and random checks against a transaction-level model
module tb_line_burst_adaptor;
  logic         clk = 0, rst = 0;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
  logic [63:0]  burst_i, burst_o;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  line_burst_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // model: one pending transaction (kind 1=fill, 2=writeback), beats taken so far, done pulse
  int           m_kind, m_beats;
  bit           m_done;
  logic [31:0]  m_addr;
  logic [255:0] m_wline, m_line;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind = 0; m_beats = 0; m_done = 0; m_addr = 0; m_wline = 0; m_line = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_kind == 0) begin
      if (write_i || read_i) begin
        m_kind  = write_i ? 2 : 1;
        m_beats = 0;
        m_addr  = address_i & 32'hFFFF_FFE0;
        if (write_i) m_wline = line_i;
      end
    end else if (resp_i) begin
      if (m_kind == 1) m_line[64*m_beats +: 64] = burst_i;
      m_beats++;
      if (m_beats == 4) begin
        m_kind = 0;
        m_done = 1;
      end
    end
  end

  logic prev_resp = 0;
  always @(negedge clk) if (chk_en) begin
    chk("read_o", read_o, m_kind == 1);
    chk("write_o", write_o, m_kind == 2);
    chk("resp_o", resp_o, m_done);
    chk("address_o", address_o, m_addr);
    chk("line_o", line_o, m_line);
    if (m_kind == 2) chk("burst_o", burst_o, m_wline[64*m_beats +: 64]);
    chk("resp_twice", resp_o & prev_resp, 0);
    prev_resp <= resp_o;
  end

  logic [255:0] exp_line, saved;
  logic [6:0]   pat;
  int           k;
  initial begin
    {read_i, write_i, resp_i} = 0;
    address_i = 0; line_i = 0; burst_i = 0;
    repeat (3) step();
    chk_en = 1;
    chk("rst_line", line_o, 0);
    chk("rst_req", {read_o, write_o, resp_o}, 0);
    chk("rst_addr", address_o, 0);
    chk("rst_burst", burst_o, 0);
    rst = 1;
    step();
    read_i = 1; address_i = 32'h0000_1234;
    step();
    read_i = 0;
    chk("fill_addr", address_o, 32'h0000_1220);
    for (int b = 0; b < 4; b++) begin
      chk("fill_read_o", read_o, 1);
      chk("fill_resp_early", resp_o, 0);
      resp_i = 1; burst_i = {16{4'(b + 1)}};
      step();
    end
    resp_i = 0;
    chk("fill_resp", resp_o, 1);
    chk("fill_read_drop", read_o, 0);
    chk("fill_line", line_o, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    step();
    chk("fill_resp_once", resp_o, 0);
    step();
    write_i = 1; line_i = {64'hD, 64'hC, 64'hB, 64'hA}; address_i = 32'hFFFF_FFE7;
    step();
    write_i = 0; line_i = '1; address_i = 0;
    chk("wr_addr", address_o, 32'hFFFF_FFE0);
    for (int b = 0; b < 4; b++) begin
      chk("wr_write_o", write_o, 1);
      chk("wr_read_o", read_o, 0);
      chk("wr_burst", burst_o, 64'(b + 10));
      resp_i = 1;
      step();
    end
    resp_i = 0;
    chk("wr_resp", resp_o, 1);
    step();
    chk("wr_resp_once", resp_o, 0);
    step();
    pat = 7'b1011001; exp_line = 0; k = 0;
    read_i = 1; address_i = 32'h0000_1000;
    step();
    read_i = 0;
    for (int i = 0; i < 7; i++) begin
      chk("stall_read_o", read_o, 1);
      chk("stall_resp_early", resp_o, 0);
      resp_i = pat[i]; burst_i = {$urandom, $urandom};
      if (resp_i) begin
        exp_line[64*k +: 64] = burst_i;
        k++;
      end
      step();
    end
    resp_i = 0;
    chk("stall_resp", resp_o, 1);
    chk("stall_line", line_o, exp_line);
    repeat (2) step();
    read_i = 1; write_i = 1; line_i = {8{$urandom}}; address_i = 32'h0000_2000;
    step();
    write_i = 0;
    for (int b = 0; b < 4; b++) begin
      chk("both_write_first", {read_o, write_o}, 2'b01);
      resp_i = 1;
      step();
    end
    resp_i = 0;
    chk("both_resp1", resp_o, 1);
    step();
    chk("both_idle", {read_o, write_o, resp_o}, 0);
    step();
    chk("both_fill_start", read_o, 1);
    read_i = 0;
    for (int b = 0; b < 4; b++) begin
      resp_i = 1; burst_i = {$urandom, $urandom};
      step();
    end
    resp_i = 0;
    chk("both_resp2", resp_o, 1);
    repeat (2) step();
    read_i = 1; address_i = 32'h0000_3000;
    step();
    read_i = 0; resp_i = 1;
    repeat (2) step();
    resp_i = 0;
    rst = 0;
    #1;
    chk("arst_read_o", read_o, 0);
    chk("arst_line", line_o, 0);
    chk("arst_addr", address_o, 0);
    step();
    rst = 1;
    step();
    read_i = 1; address_i = 32'h0000_0040; exp_line = 0;
    step();
    read_i = 0;
    chk("refill_addr", address_o, 32'h0000_0040);
    for (int b = 0; b < 4; b++) begin
      resp_i = 1; burst_i = {$urandom, $urandom}; exp_line[64*b +: 64] = burst_i;
      step();
    end
    resp_i = 0;
    chk("refill_resp", resp_o, 1);
    chk("refill_line", line_o, exp_line);
    repeat (2) step();
    saved = line_o; resp_i = 1;
    repeat (3) begin
      step();
      chk("stale_req", {read_o, write_o, resp_o}, 0);
      chk("stale_line", line_o, saved);
    end
    resp_i = 0;
    repeat (3000) begin
      read_i = $urandom_range(0, 3) == 0;
      write_i = $urandom_range(0, 5) == 0;
      resp_i = $urandom_range(0, 9) < 7;
      burst_i = {$urandom, $urandom};
      line_i = {8{$urandom}};
      address_i = $urandom;
      rst = $urandom_range(0, 199) != 0;
      step();
    end
    rst = 1; {read_i, write_i, resp_i} = 0;
    repeat (10) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
